// File: rtl/multu_if.sv
// Function-code and result bundle between ALU control, datapath and multiplier.
// The control side drives Signal and operands; the multiplier returns HI/LO and status.
interface multu_if #(
  parameter int WIDTH = 32
);
  logic [5:0]       Signal;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [WIDTH-1:0] hilo_out;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output Signal, dataA, dataB,
    input  hilo_out, hi, lo, busy, done
  );

  modport slave (
    input  Signal, dataA, dataB,
    output hilo_out, hi, lo, busy, done
  );
endinterface

// File: rtl/multu_hilo.sv
// Sequential unsigned shift-add multiplier owning the architectural HI/LO pair.
// One multiply per rising edge of MULTU on Signal; MFHI/MFLO read the registers.
module multu_hilo #(
  parameter int         WIDTH   = 32,
  parameter logic [5:0] F_MULTU = 6'd25,
  parameter logic [5:0] F_MFHI  = 6'd16,
  parameter logic [5:0] F_MFLO  = 6'd18
) (
  input  logic   clk,
  input  logic   rst,
  multu_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   mcand, mcand_nx;
  logic [2*WIDTH-1:0] product, product_nx;
  logic [CW-1:0]      count, count_nx;
  logic               lock, lock_nx;
  logic [WIDTH-1:0]   hi, hi_nx;
  logic [WIDTH-1:0]   lo, lo_nx;
  logic               busy, busy_nx;
  logic               done, done_nx;
  logic [WIDTH:0]     sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      product <= '0;
      count   <= '0;
      lock    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      mcand   <= mcand_nx;
      product <= product_nx;
      count   <= count_nx;
      lock    <= lock_nx;
      hi      <= hi_nx;
      lo      <= lo_nx;
      busy    <= busy_nx;
      done    <= done_nx;
    end
  end

  // The carry out of the partial-sum add is kept as bit WIDTH.
  always_comb begin
    sum = {1'b0, product[2*WIDTH-1:WIDTH]}
        + (product[0] ? {1'b0, mcand} : '0);
  end

  always_comb begin
    state_nx   = state;
    mcand_nx   = mcand;
    product_nx = product;
    count_nx   = count;
    lock_nx    = lock;
    hi_nx      = hi;
    lo_nx      = lo;
    busy_nx    = busy;
    done_nx    = 1'b0;

    // Holding MULTU must not retrigger, so the lock drops only when it leaves.
    if (bus.Signal != F_MULTU) begin
      lock_nx = 1'b0;
    end

    unique case (state)
      IDLE: begin
        if (bus.Signal == F_MULTU && !lock) begin
          mcand_nx   = bus.dataA;
          product_nx = {{WIDTH{1'b0}}, bus.dataB};
          count_nx   = '0;
          lock_nx    = 1'b1;
          busy_nx    = 1'b1;
          state_nx   = RUN;
        end
      end
      RUN: begin
        product_nx = {sum, product[WIDTH-1:1]};
        count_nx   = count + CW'(1);
        busy_nx    = 1'b1;
        if (count == CW'(WIDTH - 1)) begin
          state_nx = FIN;
        end
      end
      FIN: begin
        hi_nx    = product[2*WIDTH-1:WIDTH];
        lo_nx    = product[WIDTH-1:0];
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_comb begin
    bus.hilo_out = '0;
    unique case (1'b1)
      (bus.Signal == F_MFHI): bus.hilo_out = hi;
      (bus.Signal == F_MFLO): bus.hilo_out = lo;
      default:                bus.hilo_out = '0;
    endcase
  end

  assign bus.hi   = hi;
  assign bus.lo   = lo;
  assign bus.busy = busy;
  assign bus.done = done;
endmodule
